hazard_scoreboard_ctrl: RTL and testbench

//  Parametrised pipeline hazard/flush controller for the 5-stage core (PC, IF/ID, ID/EXE, EXE/MEM, MEM/WB).

---
 rtl/hazard_scoreboard_ctrl_pkg.sv | 25 ++
 rtl/hazard_scoreboard_ctrl_if.sv | 35 +++
 rtl/hazard_scoreboard_ctrl_reg_scoreboard.sv | 56 +++++
 rtl/hazard_scoreboard_ctrl.sv | 114 +++++++++++
 tb/tb_hazard_scoreboard_ctrl.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_ctrl_pkg.sv
// Shared control-path types for the pipeline hazard/flush controller:
// FSM states and the bit positions of the stall/flush vectors.
package hazard_scoreboard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    REDIR_WAIT  = 2'd1,
    FENCE_DRAIN = 2'd2,
    FENCE_FLUSH = 2'd3
  } ctrl_state_e;

  // stall vector bit positions
  localparam int STG_PC     = 0;
  localparam int STG_IFID   = 1;
  localparam int STG_IDEXE  = 2;
  localparam int STG_EXEMEM = 3;
  localparam int STG_MEMWB  = 4;

  // flush vector bit positions
  localparam int FL_IFID   = 0;
  localparam int FL_IDEXE  = 1;
  localparam int FL_EXEMEM = 2;
  localparam int FL_MEMWB  = 3;

endpackage

// File: rtl/hazard_scoreboard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: ID operands, hazard sources
// and the stall/flush/ack controls returned to the pipeline registers.
interface hazard_scoreboard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 3
);
  logic [REG_ADDR_W-1:0] rs1_addr_id;
  logic [REG_ADDR_W-1:0] rs2_addr_id;
  logic                  use_rs1_id;
  logic                  use_rs2_id;
  logic [REG_ADDR_W-1:0] rd_addr_id;
  logic                  valid_id;
  logic [CNT_W-1:0]      issue_lat;
  logic                  fence_req;
  logic                  redirect;
  logic                  trap_flush;
  logic                  if_stall;
  logic                  mem_stall;
  logic [4:0]            stall;
  logic [3:0]            flush;
  logic                  redirect_ack;
  logic                  fence_done;

  modport master (
    output rs1_addr_id, rs2_addr_id, use_rs1_id, use_rs2_id, rd_addr_id, valid_id,
    output issue_lat, fence_req, redirect, trap_flush, if_stall, mem_stall,
    input  stall, flush, redirect_ack, fence_done
  );

  modport slave (
    input  rs1_addr_id, rs2_addr_id, use_rs1_id, use_rs2_id, rd_addr_id, valid_id,
    input  issue_lat, fence_req, redirect, trap_flush, if_stall, mem_stall,
    output stall, flush, redirect_ack, fence_done
  );
endinterface

// File: rtl/hazard_scoreboard_ctrl_reg_scoreboard.sv
// Per-register latency scoreboard: cnt[r] is the number of cycles until r is
// forwardable. x0 is never written, so it always reads as ready.
module hazard_scoreboard_ctrl_reg_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clear,
  input  logic                  freeze,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [CNT_W-1:0]      wr_lat,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  busy1,
  output logic                  busy2,
  output logic                  empty
);
  localparam int N_REGS = 2 ** REG_ADDR_W;

  logic [CNT_W-1:0] cnt_r [N_REGS];
  logic             any_busy_s;

  // Counter array: the entry being written takes the new latency, all others count down.
  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      for (int i = 0; i < N_REGS; i++) cnt_r[i] <= '0;
    end else if (!freeze) begin
      for (int i = 0; i < N_REGS; i++) begin
        if (wr_en && (wr_addr == REG_ADDR_W'(i)) && (i != 0)) begin
          cnt_r[i] <= wr_lat;
        end else if (cnt_r[i] != '0) begin
          cnt_r[i] <= cnt_r[i] - CNT_W'(1);
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Empty flag over the trackable registers.
  always_comb begin
    any_busy_s = 1'b0;
    for (int i = 1; i < N_REGS; i++) begin
      any_busy_s = any_busy_s | (cnt_r[i] != '0);
    end
  end

  assign busy1 = (rs1_addr != '0) && (cnt_r[rs1_addr] != '0);
  assign busy2 = (rs2_addr != '0) && (cnt_r[rs2_addr] != '0);
  assign empty = ~any_busy_s;

endmodule

// File: rtl/hazard_scoreboard_ctrl.sv
// Hazard/flush controller for the 5-stage core: latency scoreboard, redirect-wait
// and fence drain sequencing, resolved into one stall/flush action per cycle.
module hazard_scoreboard_ctrl
  import hazard_scoreboard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MAX_LAT    = 7,
  parameter int CNT_W      = 3
) (
  input  logic                   clk,
  input  logic                   rstn,
  hazard_scoreboard_ctrl_if.slave ctrl
);
  ctrl_state_e          state_r;
  ctrl_state_e          state_nxt_s;
  logic [STG_MEMWB:0]   stall_s;
  logic [FL_MEMWB:0]    flush_s;
  logic                 redirect_ack_s;
  logic                 fence_done_s;
  logic                 busy1_s;
  logic                 busy2_s;
  logic                 sb_empty_s;
  logic                 hazard_id_s;
  logic                 fence_active_s;
  logic                 issue_fire_s;
  logic                 sb_wr_en_s;
  logic [CNT_W-1:0]     wr_lat_s;

  hazard_scoreboard_ctrl_reg_scoreboard #(
    .REG_ADDR_W (REG_ADDR_W),
    .CNT_W      (CNT_W)
  ) u_sb (
    .clk      (clk),
    .rstn     (rstn),
    .clear    (ctrl.trap_flush),
    .freeze   (ctrl.mem_stall),
    .wr_en    (sb_wr_en_s),
    .wr_addr  (ctrl.rd_addr_id),
    .wr_lat   (wr_lat_s),
    .rs1_addr (ctrl.rs1_addr_id),
    .rs2_addr (ctrl.rs2_addr_id),
    .busy1    (busy1_s),
    .busy2    (busy2_s),
    .empty    (sb_empty_s)
  );

  assign hazard_id_s    = (ctrl.use_rs1_id & busy1_s) | (ctrl.use_rs2_id & busy2_s);
  assign fence_active_s = (state_r == FENCE_DRAIN) |
                          ((state_r == RUN) & ctrl.fence_req & ctrl.valid_id);
  assign issue_fire_s   = ctrl.valid_id & ~stall_s[STG_IDEXE] & ~flush_s[FL_IDEXE] & ~hazard_id_s;
  assign sb_wr_en_s     = issue_fire_s & (ctrl.rd_addr_id != '0) & (ctrl.issue_lat != '0);
  assign wr_lat_s       = (int'(ctrl.issue_lat) > MAX_LAT) ? CNT_W'(MAX_LAT) : ctrl.issue_lat;

  // Priority mux: exactly one action per cycle, plus the next FSM state.
  always_comb begin
    stall_s        = '0;
    flush_s        = '0;
    redirect_ack_s = 1'b0;
    fence_done_s   = 1'b0;
    state_nxt_s    = state_r;
    if (!rstn) begin
      flush_s     = 4'hF;
      state_nxt_s = RUN;
    end else if (ctrl.trap_flush) begin
      flush_s     = 4'hF;
      state_nxt_s = RUN;
    end else if (ctrl.mem_stall) begin
      stall_s[STG_EXEMEM:STG_PC] = 4'hF;
      flush_s[FL_MEMWB]          = 1'b1;
    end else if ((state_r == REDIR_WAIT) || ((state_r == RUN) && ctrl.redirect)) begin
      if (ctrl.if_stall) begin
        stall_s[STG_IDEXE:STG_PC] = 3'b111;
        flush_s[FL_EXEMEM]        = 1'b1;
        state_nxt_s               = REDIR_WAIT;
      end else begin
        flush_s[FL_IDEXE:FL_IFID] = 2'b11;
        redirect_ack_s            = 1'b1;
        state_nxt_s               = RUN;
      end
    end else if ((state_r == FENCE_FLUSH) || (fence_active_s && sb_empty_s)) begin
      // Drained: the fence issues and the younger fetch is discarded for refetch.
      fence_done_s      = 1'b1;
      flush_s[FL_IFID]  = 1'b1;
      state_nxt_s       = RUN;
    end else if (fence_active_s) begin
      stall_s[STG_IFID:STG_PC] = 2'b11;
      flush_s[FL_IDEXE]        = 1'b1;
      state_nxt_s              = FENCE_DRAIN;
    end else if (hazard_id_s) begin
      stall_s[STG_IFID:STG_PC] = 2'b11;
      flush_s[FL_IDEXE]        = 1'b1;
    end else if (ctrl.if_stall) begin
      stall_s[STG_PC]  = 1'b1;
      flush_s[FL_IFID] = 1'b1;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Sequencing state.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  assign ctrl.stall        = stall_s;
  assign ctrl.flush        = flush_s;
  assign ctrl.redirect_ack = redirect_ack_s;
  assign ctrl.fence_done   = fence_done_s;

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Directed bench for hazard_scoreboard_ctrl: a per-cycle vector table followed by
// hand-written multi-cycle sequences (long-latency wait with mem_stall, trap abort).
module tb_hazard_scoreboard_ctrl;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  hazard_scoreboard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(3)) bus ();

  hazard_scoreboard_ctrl #(.REG_ADDR_W(5), .MAX_LAT(7), .CNT_W(3)) dut (
    .clk  (clk),
    .rstn (rstn),
    .ctrl (bus)
  );

  typedef struct {
    logic [63:0] tag;
    logic        rstn;
    logic        valid;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [4:0]  rd;
    logic [2:0]  lat;
    logic        fence;
    logic        redir;
    logic        trap;
    logic        ifs;
    logic        mems;
    logic [4:0]  e_stall;
    logic [3:0]  e_flush;
    logic        e_ack;
    logic        e_done;
  } vec_t;

  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl[$];

  function automatic vec_t mk(input logic [63:0] tag, input int rs_n, input int valid,
                              input int rs1, input int u1, input int rs2, input int u2,
                              input int rd, input int lat, input int fence, input int redir,
                              input int trap, input int ifs, input int mems,
                              input int es, input int ef, input int ea, input int ed);
    vec_t v;
    v.tag = tag;       v.rstn = 1'(rs_n);   v.valid = 1'(valid);
    v.rs1 = 5'(rs1);   v.u1 = 1'(u1);       v.rs2 = 5'(rs2);     v.u2 = 1'(u2);
    v.rd = 5'(rd);     v.lat = 3'(lat);     v.fence = 1'(fence); v.redir = 1'(redir);
    v.trap = 1'(trap); v.ifs = 1'(ifs);     v.mems = 1'(mems);
    v.e_stall = 5'(es); v.e_flush = 4'(ef); v.e_ack = 1'(ea);    v.e_done = 1'(ed);
    return v;
  endfunction

  function automatic vec_t idle(input logic [63:0] tag);
    return mk(tag, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic drive(input vec_t v);
    rstn             = v.rstn;
    bus.valid_id     = v.valid;
    bus.rs1_addr_id  = v.rs1;
    bus.use_rs1_id   = v.u1;
    bus.rs2_addr_id  = v.rs2;
    bus.use_rs2_id   = v.u2;
    bus.rd_addr_id   = v.rd;
    bus.issue_lat    = v.lat;
    bus.fence_req    = v.fence;
    bus.redirect     = v.redir;
    bus.trap_flush   = v.trap;
    bus.if_stall     = v.ifs;
    bus.mem_stall    = v.mems;
  endtask

  task automatic check(input vec_t v);
    n_vec++;
    if ({bus.stall, bus.flush, bus.redirect_ack, bus.fence_done} !==
        {v.e_stall, v.e_flush, v.e_ack, v.e_done}) begin
      n_err++;
      $display("FAIL %s: got stall=%b flush=%b ack=%b done=%b, want stall=%b flush=%b ack=%b done=%b",
               v.tag, bus.stall, bus.flush, bus.redirect_ack, bus.fence_done,
               v.e_stall, v.e_flush, v.e_ack, v.e_done);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    check(v);
  endtask

  // Long-latency producer into rd, then a held consumer; counts cycles with stall[1].
  task automatic div_wait(input logic [63:0] tag, input int rd, input bit with_mem, input int exp_stalls);
    vec_t v;
    int   stalls;
    bit   issued;
    apply(mk("div_iss", 1, 1, 0, 0, 0, 0, rd, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    stalls = 0;
    issued = 1'b0;
    for (int k = 0; k < 20 && !issued; k++) begin
      v = mk("div_mem", 1, 1, rd, 1, 0, 0, 0, 0, 0, 0, 0, 0,
             (with_mem && (k == 2 || k == 3)) ? 1 : 0, 'h0F, 'h8, 0, 0);
      @(negedge clk);
      drive(v);
      #1;
      if (with_mem && k == 2) check(v);
      if (bus.stall[1]) stalls++;
      else issued = 1'b1;
    end
    n_vec++;
    if (stalls != exp_stalls) begin
      n_err++;
      $display("FAIL %s: got %0d stall cycles, want %0d", tag, stalls, exp_stalls);
    end
    apply(idle("div_idle"));
  endtask

  initial begin
    drive(mk("init", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'hF, 0, 0));

    //          tag         rn v  rs1 u1 rs2 u2 rd lat fn rd tr if ms  stall flush ack done
    tbl.push_back(mk("rst0",     0, 1, 5, 1, 5, 1, 5, 3, 1, 1, 0, 1, 1, 'h00, 'hF, 0, 0));
    tbl.push_back(mk("rst1",     0, 1, 5, 1, 5, 1, 5, 3, 1, 1, 0, 1, 1, 'h00, 'hF, 0, 0));
    tbl.push_back(idle("idle0"));
    tbl.push_back(mk("ld_x5",    1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 'h00, 'h0, 0, 0));
    tbl.push_back(mk("use_x5",   1, 1, 5, 1, 1, 1, 6, 0, 0, 0, 0, 0, 0, 'h03, 'h2, 0, 0));
    tbl.push_back(mk("iss_x6",   1, 1, 5, 1, 1, 1, 6, 0, 0, 0, 0, 0, 0, 'h00, 'h0, 0, 0));
    tbl.push_back(mk("x0_div",   1, 1, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 'h00, 'h0, 0, 0));
    tbl.push_back(mk("use_x0",   1, 1, 0, 1, 0, 1,11, 0, 0, 0, 0, 0, 0, 'h00, 'h0, 0, 0));
    tbl.push_back(mk("waw_a",    1, 1, 0, 0, 0, 0,10, 5, 0, 0, 0, 0, 0, 'h00, 'h0, 0, 0));
    tbl.push_back(mk("waw_b",    1, 1, 0, 0, 0, 0,10, 1, 0, 0, 0, 0, 0, 'h00, 'h0, 0, 0));
    tbl.push_back(mk("waw_use",  1, 1, 0, 0,10, 1, 0, 0, 0, 0, 0, 0, 0, 'h03, 'h2, 0, 0));
    tbl.push_back(mk("waw_iss",  1, 1, 0, 0,10, 1, 0, 0, 0, 0, 0, 0, 0, 'h00, 'h0, 0, 0));
    tbl.push_back(mk("ld_x12",   1, 1, 0, 0, 0, 0,12, 2, 0, 0, 0, 0, 0, 'h00, 'h0, 0, 0));
    tbl.push_back(mk("nouse",    1, 1,12, 0,12, 0, 0, 0, 0, 0, 0, 0, 0, 'h00, 'h0, 0, 0));
    tbl.push_back(idle("idle1"));
    tbl.push_back(mk("ifs",      1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'h01, 'h1, 0, 0));
    tbl.push_back(mk("redir_w0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 'h07, 'h4, 0, 0));
    tbl.push_back(mk("redir_w1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 'h07, 'h4, 0, 0));
    tbl.push_back(mk("redir_w2", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 'h07, 'h4, 0, 0));
    tbl.push_back(mk("redir_ak", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 'h00, 'h3, 1, 0));
    tbl.push_back(idle("idle2"));
    tbl.push_back(mk("mem_rdr",  1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 'h0F, 'h8, 0, 0));
    tbl.push_back(mk("redir_a2", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 'h00, 'h3, 1, 0));
    tbl.push_back(idle("idle3"));
    tbl.push_back(mk("mul_x8",   1, 1, 0, 0, 0, 0, 8, 3, 0, 0, 0, 0, 0, 'h00, 'h0, 0, 0));
    tbl.push_back(mk("fence0",   1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 'h03, 'h2, 0, 0));
    tbl.push_back(mk("fence1",   1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 'h03, 'h2, 0, 0));
    tbl.push_back(mk("fence2",   1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 'h03, 'h2, 0, 0));
    tbl.push_back(mk("fence_dn", 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 'h00, 'h1, 0, 1));
    tbl.push_back(idle("idle4"));
    tbl.push_back(mk("fence_e",  1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 'h00, 'h1, 0, 1));
    tbl.push_back(idle("idle5"));

    foreach (tbl[i]) apply(tbl[i]);

    div_wait("div5", 7, 1'b0, 5);
    div_wait("div_mem7", 7, 1'b1, 7);

    // Trap aborts a fence drain while x9 still has 4 cycles to go.
    apply(mk("div_x9",   1, 1, 0, 0, 0, 0, 9, 5, 0, 0, 0, 0, 0, 'h00, 'h0, 0, 0));
    apply(mk("fnc_drn",  1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 'h03, 'h2, 0, 0));
    apply(mk("trap",     1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 'h00, 'hF, 0, 0));
    apply(mk("post_trp", 1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h00, 'h0, 0, 0));
    apply(idle("idle6"));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
